cond_logic: RTL
===============

Name: cond_logic

Overview:
- Conditional-execution stage that sits directly downstream of the ALU decoder and main decoder in the ARM-subset single-cycle datapath.
- Holds the architectural NZCV flag register and updates it under FlagW/NoWrite control from the decoder.
- Evaluates the instruction's 4-bit condition field against the stored flags.
- Gates PCSrc, RegWrite and MemWrite so that failed-condition instructions have no architectural effect.

Parameters:
- FLAG_RST, 4'b0000: NZCV value loaded on reset.
- CNT_W, 32: width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  ALU result flags {N,Z,C,V} for the current instruction.
- FlagW  input  2  flag-write enables from the ALU decoder: [1] writes N,Z; [0] writes C,V.
- PCS  input  1  decoder request to write the PC.
- RegW  input  1  decoder request to write the register file.
- MemW  input  1  decoder request to write memory.
- NoWrite  input  1  ALU decoder suppress-register-write (CMP/CMN class).
- Stall  input  1  hold this stage; the current cycle is a bubble.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  condition passed.
- Flags  output  4  current registered {N,Z,C,V}.

Behaviour:
- Flags register, 4 bits, bit3=N, bit2=Z, bit1=C, bit0=V; Flags output is driven directly from the register.
- On a rising edge with reset=1: Flags <= FLAG_RST; no other state changes.
- On a rising edge with reset=0 and Stall=0:
  - if FlagW[1] & CondEx: N,Z <= ALUFlags[3:2]
  - if FlagW[0] & CondEx: C,V <= ALUFlags[1:0]
  - the two halves update independently.
- On a rising edge with Stall=1: Flags hold.
- Flag latency is one cycle. The instruction in cycle t evaluates Cond against flags written by instruction t-1. There is no same-cycle bypass: an instruction never sees its own ALUFlags.
- CondEx is combinational from Cond and the registered Flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 1 (treated as AL)
- Output gating (combinational, with K = !reset & !Stall):
  - PCSrc = PCS & CondEx & K
  - RegWrite = RegW & CondEx & !NoWrite & K
  - MemWrite = MemW & CondEx & K
- While reset=1, all three write outputs are 0, CondEx still reflects Cond vs Flags, and Flags shows the register value (FLAG_RST from the first reset edge onward).
- A failed condition blocks both the flag update and all three writes (e.g. CMPNE with Z=1 leaves the flags unchanged).
- Reset asserted mid-operation: the pending flag write in that cycle is discarded; FLAG_RST wins.
- Stall and reset asserted together: reset wins.
- X on FlagW from the decoder's default arm must not reach Flags. The decoder drives FlagW=00 on illegal ops; a bench assertion checks that FlagW is never X while reset=0.

Optional Feature:
- Macro: COND_STATS_EN.
- Compiled in:
  - adds outputs ExecCount[CNT_W-1:0] and SquashCount[CNT_W-1:0], both reset to 0.
  - each non-stalled, non-reset edge increments exactly one of them: ExecCount if CondEx=1, else SquashCount.
  - counters wrap modulo 2^CNT_W.
  - Stall=1 cycles are counted by neither.
- Compiled out: ports and logic absent; all other behaviour identical.

Decomposition:
- Package cond_pkg holds:
  - localparams for the 16 condition encodings (COND_EQ .. COND_AL)
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - FlagW bit indices FW_NZ=1, FW_CV=0
- One natural combinational sub-module: cond_check, with inputs Cond[3:0] and Flags[3:0] and output CondEx. It is instantiated once and reused by the verification bench as a reference model.
- The flag register, gating and counters stay in cond_logic.

Test Plan:
- Reset then ADDS with ALUFlags=0100, FlagW=11, Cond=1110 -> next cycle Flags=0100; following BEQ (Cond=0000, PCS=1) gives PCSrc=1, CondEx=1.
- Flags=0100, SUBNE (Cond=0001, RegW=1, FlagW=11, ALUFlags=1000) -> CondEx=0, RegWrite=0, Flags remain 0100 next cycle.
- CMP with NoWrite=1, RegW=1, FlagW=11, ALUFlags=0010, Cond=1110 -> RegWrite=0, Flags=0010 next cycle; a subsequent HI (1000) gives CondEx=1 and LS (1001) gives CondEx=0.
- FlagW=10 only, ALUFlags=1111 from Flags=0000 -> Flags=1100 (C,V untouched); then FlagW=01, ALUFlags=0001 -> Flags=1101.
- Stall=1 with FlagW=11, ALUFlags=1010, MemW=1, Cond=1110 -> MemWrite=0, Flags unchanged; reset pulse concurrent with a flag write -> Flags=FLAG_RST, all write outputs 0.
- COND_STATS_EN: 5 AL instructions, 3 failing EQ (Z=0), 2 stalled cycles -> ExecCount=5, SquashCount=3; with CNT_W=4, 17 executes -> ExecCount=1.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage: condition
// encodings, NZCV bit positions and FlagW enable bit positions.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: compares a 4-bit condition field
// against a registered NZCV value. Encoding 1111 behaves as AL.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  // Decode the condition field into a single pass/fail bit
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: owns the NZCV flag register, evaluates the
// instruction condition against it and gates the PC/register/memory writes.
// Optional statistics counters are compiled in with `define COND_STATS_EN.
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
`ifdef COND_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             Stall,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
`endif
);

  logic [3:0] flags_q;
  logic       cond_ex;
  logic       active;

  // The condition always sees last cycle's flags; no same-cycle bypass.
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  assign active   = ~reset & ~Stall;
  assign CondEx   = cond_ex;
  assign Flags    = flags_q;
  assign PCSrc    = PCS  & cond_ex & active;
  assign RegWrite = RegW & cond_ex & ~NoWrite & active;
  assign MemWrite = MemW & cond_ex & active;

  // Flag register: NZ and CV halves update independently, only for
  // instructions that pass their condition and are not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RST;
    end else if (~Stall & cond_ex) begin
      if (FlagW[FW_NZ] == 1'b1) begin
        flags_q[FLAG_N] <= ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagW[FW_CV] == 1'b1) begin
        flags_q[FLAG_C] <= ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;

  assign ExecCount   = exec_cnt;
  assign SquashCount = squash_cnt;

  // Every issued (non-stalled) instruction lands in exactly one counter
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (~Stall) begin
      if (cond_ex) begin
        exec_cnt <= exec_cnt + CNT_W'(1);
      end else begin
        squash_cnt <= squash_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
